// File: rtl/input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : input_conditioner                                               |
// | Brief    : 2-FF sync + per-channel debounce + rising-edge pulses for the   |
// |            crane operator inputs; mode register for main's mode_in.        |
// |            Macro INPUT_COND_MODE_LOCK_EN: mode_out loads only on write key.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hooked_raw,
  input  logic       unhooked_raw,
  input  logic       write_raw,
  input  logic [1:0] mode_raw,
  output logic       hooked,
  output logic       unhooked,
  output logic       hooked_pulse,
  output logic       unhooked_pulse,
  output logic       write_pulse,
  output logic [1:0] mode_out,
  output logic       mode_valid,
  output logic       conflict
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int               c_NBIT    = 3;

  logic [c_NBIT-1:0] raw_bits;
  logic [c_NBIT-1:0] lvl_q;
  logic [c_NBIT-1:0] lvl_d;
  logic [c_NBIT-1:0] pulse_q;

  assign raw_bits = {write_raw, unhooked_raw, hooked_raw};

  // Scalar channels: bit 0 hooked, bit 1 unhooked, bit 2 write key
  for (genvar gi = 0; gi < c_NBIT; gi++) begin : g_bit
    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (s2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == c_CNT_MAX) begin
        stable_d = s2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        s1_q     <= raw_bits[gi];
        s2_q     <= s1_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign lvl_q[gi] = stable_q;
    assign lvl_d[gi] = stable_d;
  end

  // Mode selector is debounced as a whole vector; any non-stable value keeps the count running
  logic [1:0]       mode_s1_q;
  logic [1:0]       mode_s2_q;
  logic [1:0]       mode_stable_q;
  logic [1:0]       mode_stable_d;
  logic [CNT_W-1:0] mode_cnt_q;
  logic [CNT_W-1:0] mode_cnt_d;

  always_comb begin
    mode_stable_d = mode_stable_q;
    mode_cnt_d    = mode_cnt_q;
    if (mode_s2_q == mode_stable_q) begin
      mode_cnt_d = '0;
    end else if (mode_cnt_q == c_CNT_MAX) begin
      mode_stable_d = mode_s2_q;
      mode_cnt_d    = '0;
    end else begin
      mode_cnt_d = mode_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_s1_q     <= 2'b00;
      mode_s2_q     <= 2'b00;
      mode_stable_q <= 2'b00;
      mode_cnt_q    <= '0;
    end else begin
      mode_s1_q     <= mode_raw;
      mode_s2_q     <= mode_s1_q;
      mode_stable_q <= mode_stable_d;
      mode_cnt_q    <= mode_cnt_d;
    end
  end

  logic [1:0] mode_out_q;
  logic [1:0] mode_out_d;
  logic       mode_valid_q;
  logic       mode_valid_d;

`ifdef INPUT_COND_MODE_LOCK_EN
  always_comb begin
    mode_out_d   = mode_out_q;
    mode_valid_d = mode_valid_q;
    if (pulse_q[2]) begin
      mode_out_d   = mode_stable_q;
      mode_valid_d = 1'b1;
    end
  end
`else
  always_comb begin
    mode_out_d   = mode_stable_d;
    mode_valid_d = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_q      <= '0;
      mode_out_q   <= 2'b00;
      mode_valid_q <= 1'b0;
    end else begin
      pulse_q      <= lvl_d & ~lvl_q;
      mode_out_q   <= mode_out_d;
      mode_valid_q <= mode_valid_d;
    end
  end

  assign hooked         = lvl_q[0];
  assign unhooked       = lvl_q[1];
  assign hooked_pulse   = pulse_q[0];
  assign unhooked_pulse = pulse_q[1];
  assign write_pulse    = pulse_q[2];
  assign mode_out       = mode_out_q;
  assign mode_valid     = mode_valid_q;
  assign conflict       = lvl_q[0] & lvl_q[1];

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_input_conditioner                                            |
// | Brief    : Scoreboard bench for input_conditioner with a sliding-window    |
// |            debounce reference model.                                       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_input_conditioner;

  localparam int D = 4;

  logic       clk;
  logic       r_rstn, r_h, r_u, r_w;
  logic [1:0] r_m;
  logic       hooked, unhooked, hooked_pulse, unhooked_pulse, write_pulse;
  logic [1:0] mode_out;
  logic       mode_valid, conflict;

  input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(r_rstn),
    .hooked_raw(r_h), .unhooked_raw(r_u), .write_raw(r_w), .mode_raw(r_m),
    .hooked(hooked), .unhooked(unhooked),
    .hooked_pulse(hooked_pulse), .unhooked_pulse(unhooked_pulse),
    .write_pulse(write_pulse), .mode_out(mode_out),
    .mode_valid(mode_valid), .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef INPUT_COND_MODE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] out_vec();
    return {hooked, unhooked, hooked_pulse, unhooked_pulse, write_pulse,
            mode_out, mode_valid, conflict};
  endfunction

  // Reference model: a level changes once the synchronised sample has differed
  // from it on each of the last D edges since reset.
  logic [4:0] hist[$];      // raw sample per edge: {mode, w, u, h}
  int         edge_n;
  logic [1:0] st[4];
  logic       m_wp, m_valid;
  logic [1:0] m_mode;
  logic [8:0] exp_q[$];

  function automatic logic [1:0] fld(input logic [4:0] s, input int c);
    if (c == 3) return s[4:3];
    return {1'b0, s[c]};
  endfunction

  function automatic logic [4:0] s2_at(input int k);
    return (k < 2) ? 5'd0 : hist[k-2];
  endfunction

  task automatic model_step();
    logic [1:0] nst[4];
    logic [2:0] pul;
    bit         diff;
    if (!r_rstn) begin
      hist.delete();
      edge_n = 0;
      for (int c = 0; c < 4; c++) st[c] = 2'b00;
      m_wp = 1'b0; m_mode = 2'b00; m_valid = 1'b0;
      exp_q.push_back(9'd0);
      return;
    end
    hist.push_back({r_m, r_w, r_u, r_h});
    for (int c = 0; c < 4; c++) begin
      nst[c] = st[c];
      if (edge_n >= D - 1) begin
        diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (fld(s2_at(edge_n - j), c) == st[c]) diff = 1'b0;
        if (diff) nst[c] = fld(s2_at(edge_n), c);
      end
    end
    for (int c = 0; c < 3; c++) pul[c] = nst[c][0] & ~st[c][0];
    if (LOCK) begin
      if (m_wp) begin m_mode = st[3]; m_valid = 1'b1; end
    end else begin
      m_mode = nst[3]; m_valid = 1'b1;
    end
    m_wp = pul[2];
    for (int c = 0; c < 4; c++) st[c] = nst[c];
    edge_n++;
    exp_q.push_back({st[0][0], st[1][0], pul[0], pul[1], pul[2], m_mode, m_valid,
                     st[0][0] & st[1][0]});
  endtask

  // One clock cycle of stimulus: inputs are already set, expected result queued
  task automatic cycle();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Edges until the chosen DUT condition holds (bounded)
  task automatic wait_for(input int sel, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 40) begin
      cycle();
      n++;
      case (sel)
        0:       hit = (hooked === 1'b1);
        1:       hit = (hooked === 1'b0);
        default: hit = (hooked_pulse === 1'b1);
      endcase
    end
  endtask

  // Monitor: outputs are free-running, so every edge yields one comparison
  initial begin
    logic [8:0] e;
    int         cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("outputs[%0d]", cyc), 32'(out_vec()), 32'(e));
      end
      cyc++;
    end
  end

  initial begin
    int  n, both;
    bit  seen;
    r_rstn = 1'b0; r_h = 1'b0; r_u = 1'b0; r_w = 1'b0; r_m = 2'd0;
    #1;
    chk("reset_state", 32'(out_vec()), 32'd0);
    cycles(3);
    r_rstn = 1'b1;
    cycles(5);

    // Clean press and release
    r_h = 1'b1;
    wait_for(0, n);
    chk("press_latency", 32'(n), 32'(D + 2));
    cycles(20 - n);
    r_h = 1'b0;
    wait_for(1, n);
    chk("release_latency", 32'(n), 32'(D + 2));
    cycles(10);

    // Glitches shorter than the debounce window
    seen = 1'b0;
    r_u = 1'b1; for (int i = 0; i < 3; i++) begin cycle(); seen |= unhooked | unhooked_pulse; end
    r_u = 1'b0; for (int i = 0; i < 3; i++) begin cycle(); seen |= unhooked | unhooked_pulse; end
    r_u = 1'b1; for (int i = 0; i < 2; i++) begin cycle(); seen |= unhooked | unhooked_pulse; end
    r_u = 1'b0; for (int i = 0; i < 10; i++) begin cycle(); seen |= unhooked | unhooked_pulse; end
    chk("glitch_rejected", 32'(seen), 32'd0);

    // Mode tracking / locking
    r_m = 2'd2;
    cycles(12);
    chk("mode_no_press", 32'(mode_out), LOCK ? 32'd0 : 32'd2);
    r_m = 2'd1;
    cycles(10);
    r_w = 1'b1;
    cycles(8);
    r_w = 1'b0;
    cycles(8);
    chk("mode_after_press", 32'({mode_out, mode_valid}), 32'({2'd1, 1'b1}));
    r_m = 2'd3;
    cycles(30);
    chk("mode_after_change", 32'(mode_out), LOCK ? 32'd1 : 32'd3);

    // Simultaneous hook and unhook
    both = 0;
    r_h = 1'b1; r_u = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (hooked_pulse && unhooked_pulse) both++;
    end
    chk("simult_pulses", 32'(both), 32'd1);
    chk("conflict_held", 32'(conflict), 32'd1);

    // Asynchronous reset with levels high
    r_rstn = 1'b0;
    #1;
    chk("async_reset_clear", 32'(out_vec()), 32'd0);
    r_h = 1'b0; r_u = 1'b0;
    cycles(2);
    r_rstn = 1'b1;
    cycles(4);

    // Reset two cycles into a count, input held through release
    r_h = 1'b1;
    cycles(2);
    r_rstn = 1'b0;
    #1;
    chk("midcount_reset", 32'(out_vec()), 32'd0);
    cycles(2);
    r_rstn = 1'b1;
    wait_for(2, n);
    chk("post_reset_pulse", 32'(n), 32'(D + 2));
    cycles(5);

    // Randomised traffic with hold times around the debounce window
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) r_h = ~r_h;
      if ($urandom_range(0, 4) == 0) r_u = ~r_u;
      if ($urandom_range(0, 4) == 0) r_w = ~r_w;
      if ($urandom_range(0, 4) == 0) r_m = 2'($urandom_range(0, 3));
      r_rstn = ($urandom_range(0, 299) != 0);
      cycle();
    end
    r_rstn = 1'b1;
    cycles(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioner for the crane controller's operator inputs: the hook/unhook switches, the write-mode key and the 2-bit mode selector. It synchronises each raw input to `clk` and debounces it with a per-channel counter. It then hands clean levels and one-cycle rising-edge pulses to the `main` control block. A mode register latches the selector for `main`'s `mode_in`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles an input must differ from its stable value before the stable value changes (1 ms at 50 MHz). Legal range 2..2^20.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width.

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately
- `hooked_raw`  in  1  raw hook switch, asynchronous
- `unhooked_raw`  in  1  raw unhook switch, asynchronous
- `write_raw`  in  1  raw write-mode key, asynchronous
- `mode_raw`  in  2  raw mode selector, asynchronous
- `hooked`  out  1  debounced hook level
- `unhooked`  out  1  debounced unhook level
- `hooked_pulse`  out  1  one-cycle pulse on `hooked` 0->1
- `unhooked_pulse`  out  1  one-cycle pulse on `unhooked` 0->1
- `write_pulse`  out  1  one-cycle pulse on debounced write key 0->1
- `mode_out`  out  2  mode delivered to `main`
- `mode_valid`  out  1  `mode_out` has been loaded at least once since reset
- `conflict`  out  1  `hooked` and `unhooked` are both high

## Operation
- There are four channels: hooked, unhooked, write (1 bit each) and mode (2-bit vector).
- **Synchroniser:** each channel passes through a 2-FF synchroniser (`s1` -> `s2`).
- **Debouncer state:** each channel holds `stable` and `cnt`.
- **Debounce rule:**
  - If `s2 == stable`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= s2` and `cnt <= 0`.
  - Else `cnt <= cnt + 1`.
- **Mode channel:** debounced as a vector. Any change of `s2` to a different non-stable value during a count does not restart the count (the mismatch persists). The value taken is `s2` at the final edge.
- **Pulses:**
  - Registered: `pulse <= (stable_next & ~stable)`.
  - Pulses are high in the same cycle the level first reads 1, for exactly one cycle.
  - Falling edges produce no pulse.
- **Conflict:** `conflict = hooked & unhooked`, combinational from the registered levels. Both pulses may fire in the same cycle and are not suppressed. Arbitration belongs to `main`.
- **Mode register:** behaviour is set by `MODE_LOCK_EN` (see Configuration).
- **Counter arithmetic:** `cnt` never exceeds `DEBOUNCE_CYCLES-1` and has no wrap-around.

## Timing
- **Reset values:** every output is 0 (`hooked`, `unhooked`, all pulses, `mode_out`=2'b00, `mode_valid`, `conflict`). Sync regs, `stable` and `cnt` are also 0.
- **Latency:** a raw change first sampled at edge E0 appears on the level output after edge E0+1+`DEBOUNCE_CYCLES`, i.e. `DEBOUNCE_CYCLES`+2 cycles. The pulse aligns with that same edge.
- **Glitch rejection:** a glitch that holds `s2` off `stable` for fewer than `DEBOUNCE_CYCLES` consecutive edges changes nothing.
- **Reset during a count:** the count is discarded. An input held high through reset release produces a level rise and pulse `DEBOUNCE_CYCLES`+2 cycles after the first edge following release.
- **Mode load:** with the lock enabled, `mode_out` updates on the edge after `write_pulse` is high, so it is visible 1 cycle after the pulse.
- **Handshake:** none. Outputs are free-running and `main` samples them every cycle.

## Configuration
- Macro: `INPUT_COND_MODE_LOCK_EN`.
- **Defined:** `mode_out <= mode_stable` only on cycles where `write_pulse` is 1. `mode_valid` is set on the first load and stays 1 until reset. Selector changes without a write key press are ignored.
- **Undefined:** `mode_out` tracks the debounced mode every cycle. `mode_valid` goes to 1 at the first edge after reset release. `write_pulse` is still generated for `main`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Clean press:** `hooked_raw` 0->1, held 20 cycles -> `hooked`=1 and `hooked_pulse`=1 for one cycle, exactly 6 cycles after the first sampling edge. `hooked` falls 6 cycles after release with no pulse.
- **Glitch rejection:** `unhooked_raw` high for 3 cycles, low, then high for 2 cycles -> `unhooked` and `unhooked_pulse` stay 0 throughout.
- **Mode lock (macro defined):** `mode_raw`=2'd1, then a `write_raw` press -> `mode_out`=1 and `mode_valid`=1 one cycle after `write_pulse`. Then `mode_raw`=2'd3 for 30 cycles with no press -> `mode_out` stays 1.
- **Mode track (macro undefined):** `mode_raw` 0->2 -> `mode_out`=2 after 6 cycles, with no write press.
- **Simultaneous inputs:** `hooked_raw` and `unhooked_raw` rise on the same edge -> both pulses on the same cycle, and `conflict`=1 while both are held.
- **Reset mid-count:** `reset` driven low 2 cycles into a `hooked_raw` count -> all outputs are 0 immediately. After release with input still high, `hooked_pulse` fires 6 cycles after the first edge following release.
